// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave responder: oversamples the SPI pins on clk, delivers received bytes
// as strobes and shifts out bytes taken from a single-entry tx holding register.
module spi_slave_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    // state | meaning
    // IDLE  | csn deasserted, MISO tristated, waiting for csn fall
    // SHIFT | frame active, bits move on sck rise (rx) and fall (tx)
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   csn_d;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_sr;
    logic [6:0]             tx_rest;
    logic [7:0]             hold_data;
    logic                   hold_full;

    logic       sck_s, csn_s, mosi_s;
    logic       sck_rise, sck_fall, csn_rise, csn_fall;
    logic       load_byte, tx_hs;
    logic [7:0] next_byte;
    logic [7:0] rx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            csn_d     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            csn_d     <= csn_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign csn_rise = csn_s & ~csn_d;
    assign csn_fall = ~csn_s & csn_d;

    // A byte boundary load always takes the holding content present before this edge;
    // a handshake in the same cycle lands in the holding register for the next boundary.
    assign next_byte = hold_full ? hold_data : IDLE_BYTE;
    assign load_byte = ((state == IDLE) && csn_fall) ||
                       ((state == SHIFT) && !csn_rise && sck_fall && (bit_cnt == 3'd0));
    assign tx_hs     = tx_valid && !hold_full;
    assign tx_ready  = !hold_full;
    assign rx_next   = {rx_sr[6:0], mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            rx_sr       <= 8'h00;
            tx_rest     <= 7'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
            hold_data   <= 8'h00;
            hold_full   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (load_byte) begin
                hold_full <= 1'b0;
                tx_rest   <= next_byte[6:0];
                spi_miso  <= next_byte[7];
            end
            if (tx_hs) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        state       <= SHIFT;
                        spi_miso_oe <= 1'b1;
                        busy        <= 1'b1;
                        bit_cnt     <= 3'd0;
                    end
                end
                SHIFT: begin
                    if (csn_rise) begin
                        state       <= IDLE;
                        spi_miso_oe <= 1'b0;
                        busy        <= 1'b0;
                        bit_cnt     <= 3'd0;
                        spi_miso    <= 1'b1;
                    end else begin
                        if (sck_rise) begin
                            rx_sr   <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                            end
                        end
                        if (sck_fall && (bit_cnt != 3'd0)) begin
                            spi_miso <= tx_rest[6];
                            tx_rest  <= {tx_rest[5:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: table of single-byte frames plus hand-written
// multi-byte, handshake-overlap, abort and reset sequences.
module tb_spi_slave_responder;

    localparam int HP = 8;   // SCK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;

    int tests = 0;
    int failed = 0;
    int rx_cnt = 0;
    logic [7:0] rx_log [0:63];
    logic hs_done;

    spi_slave_responder #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            if (rx_cnt < 64) rx_log[rx_cnt] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
    end

    typedef struct {
        logic       offer;
        logic [7:0] tx_byte;
        logic [7:0] mosi_byte;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        check("tx_ready_for_handshake", {31'd0, tx_ready}, 32'd1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        hs_done = 1'b1;
    endtask

    task automatic csn_low();
        @(negedge clk);
        spi_csn = 1'b0;
        wait_clks(HP);
    endtask

    task automatic csn_high();
        @(negedge clk);
        spi_csn = 1'b1;
        wait_clks(HP);
    endtask

    // Clocks nbits mode-0 bits, MSB aligned at bit 15; MISO sampled at each raw SCK rise.
    task automatic spi_bits(input int nbits, input logic [15:0] mosi_bits, output logic [15:0] miso_bits);
        miso_bits = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            spi_mosi = mosi_bits[15-i];
            wait_clks(HP);
            spi_sck = 1'b1;
            miso_bits[15-i] = spi_miso;
            wait_clks(HP);
            spi_sck = 1'b0;
        end
        wait_clks(HP);
    endtask

    initial begin
        logic [15:0] miso;
        int          base;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        hs_done = 1'b0;

        wait_clks(3);
        check("rst_miso", {31'd0, spi_miso}, 32'd1);
        check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clks(50);
        check("idle_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_rx_count", rx_cnt, 0);

        for (int v = 0; v < 4; v++) begin
            base = rx_cnt;
            if (vecs[v].offer) offer(vecs[v].tx_byte);
            csn_low();
            check("frame_busy", {31'd0, busy}, 32'd1);
            check("frame_oe", {31'd0, spi_miso_oe}, 32'd1);
            spi_bits(8, {vecs[v].mosi_byte, 8'h00}, miso);
            csn_high();
            check("vec_miso", {24'd0, miso[15:8]}, {24'd0, vecs[v].exp_miso});
            check("vec_rx_count", rx_cnt - base, 1);
            check("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[v].exp_rx});
            check("vec_tx_ready", {31'd0, tx_ready}, 32'd1);
        end

        // Two-byte frame with no tx byte offered
        base = rx_cnt;
        csn_low();
        spi_bits(16, 16'h0180, miso);
        csn_high();
        check("two_byte_miso", {16'd0, miso}, 32'h0000FFFF);
        check("two_byte_rx_count", rx_cnt - base, 2);
        check("two_byte_rx0", {24'd0, rx_log[base]}, 32'h01);
        check("two_byte_rx1", {24'd0, rx_log[base+1]}, 32'h80);

        // Second handshake must wait until the first held byte loads at csn fall
        offer(8'h11);
        hs_done = 1'b0;
        fork
            offer(8'h22);
            begin
                wait_clks(20);
                check("hold_full_tx_ready", {31'd0, tx_ready}, 32'd0);
                check("hold_full_no_hs", {31'd0, hs_done}, 32'd0);
                csn_low();
                spi_bits(16, 16'h0000, miso);
                csn_high();
            end
        join
        check("overlap_hs_done", {31'd0, hs_done}, 32'd1);
        check("overlap_miso", {16'd0, miso}, 32'h00001122);

        // Abort after 5 bits: no rx_valid, oe drops exactly SYNC_STAGES+1 clks after csn rise
        base = rx_cnt;
        csn_low();
        spi_bits(5, 16'hFFFF, miso);
        @(negedge clk);
        spi_csn = 1'b1;
        wait_clks(2);
        check("abort_oe_before", {31'd0, spi_miso_oe}, 32'd1);
        wait_clks(1);
        check("abort_oe_after", {31'd0, spi_miso_oe}, 32'd0);
        check("abort_busy_after", {31'd0, busy}, 32'd0);
        wait_clks(HP);
        check("abort_rx_count", rx_cnt - base, 0);
        csn_low();
        spi_bits(8, 16'h5A00, miso);
        csn_high();
        check("after_abort_rx_count", rx_cnt - base, 1);
        check("after_abort_rx_data", {24'd0, rx_data}, 32'h5A);

        // Reset mid-frame with a byte held; reset must empty the holding register too
        offer(8'h77);
        csn_low();
        spi_bits(3, 16'hE000, miso);
        @(negedge clk);
        rst = 1'b1;
        wait_clks(2);
        check("midrst_miso", {31'd0, spi_miso}, 32'd1);
        check("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        spi_csn = 1'b1;
        wait_clks(HP);
        rst = 1'b0;
        wait_clks(HP);
        base = rx_cnt;
        csn_low();
        spi_bits(8, 16'hC300, miso);
        csn_high();
        check("post_rst_rx_count", rx_cnt - base, 1);
        check("post_rst_rx_data", {24'd0, rx_data}, 32'hC3);
        check("post_rst_miso", {24'd0, miso[15:8]}, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
SPI mode-0 slave: the responder end of the SPI master interface (spi_sck/spi_mosi/spi_miso/spi_csn) that the leon3mp top drives off-chip.
- Used to emulate an SPI peripheral (boot-flash stand-in, fault-injection target) inside a second FPGA or in simulation.
- Oversamples the SPI pins on the system clock.
- Presents received bytes as one-cycle strobes.
- Returns transmit bytes supplied through a valid/ready holding register.

Parameters:
SYNC_STAGES, 2, flip-flop stages on spi_sck, spi_csn and spi_mosi (min 2)
IDLE_BYTE, 8'hFF, byte shifted out on MISO when no tx byte is held at a byte boundary

Ports:
clk  in  1  system clock; must run at least 8x the SPI SCK frequency
rst  in  1  asynchronous active-high reset
spi_sck  in  1  SPI clock from master, asynchronous
spi_csn  in  1  chip select from master, active low, asynchronous
spi_mosi  in  1  master-out data, asynchronous
spi_miso  out  1  slave-out data
spi_miso_oe  out  1  MISO output enable (board tristate control)
rx_data  out  8  last complete received byte
rx_valid  out  1  one-clk strobe: rx_data updated
tx_data  in  8  next byte to return
tx_valid  in  1  tx_data offered
tx_ready  out  1  holding register empty
busy  out  1  high while CSN is asserted (synchronized)

Behaviour:
- Reset values: spi_miso=1, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0; bit counter=0, state=IDLE.
- Synchronization and edge detection:
  - sck, csn and mosi each pass through SYNC_STAGES flops.
  - One extra registered copy of sck and csn is kept for edge detection.
  - All rise/fall events below refer to the synchronized signals.
- Tx holding register (single entry):
  - Load when tx_valid && tx_ready; tx_ready drops the following cycle.
  - It empties when consumed at a byte load; tx_ready rises the following cycle.
  - tx_valid while tx_ready=0 is ignored; the source must hold the byte.
- State IDLE:
  - spi_miso_oe=0, busy=0.
  - On csn fall, go to SHIFT. In the same cycle:
    - tx shift reg <= holding byte if full (holding is consumed), else IDLE_BYTE;
    - spi_miso <= bit 7 of that byte;
    - spi_miso_oe=1, busy=1, bit counter=0.
- State SHIFT:
  - sck rise: rx shift reg <= {rx[6:0], mosi}; counter increments (3-bit, wraps 7->0).
    - On the rise where the counter was 7: rx_data <= completed byte, rx_valid=1 for exactly one clk.
  - sck fall:
    - If counter!=0: tx shift reg shifts left and spi_miso <= new bit 7.
    - If counter==0 (byte boundary): load the next byte by the same rule as at csn fall; spi_miso <= its bit 7.
    - Net effect: MSB first; each bit is valid before the master's sampling edge.
  - csn rise (any point):
    - go to IDLE; spi_miso_oe=0 and busy=0 the next cycle;
    - a partial rx byte is discarded (no rx_valid); counter clears;
    - a partly shifted tx byte is dropped; the holding register is untouched.
  - csn rise and sck edge in the same cycle: csn wins; the sck edge is ignored.
  - A byte load and a tx handshake in the same cycle: the load uses the old holding content (or IDLE_BYTE if empty); the new byte is captured for the next boundary.
- Latency:
  - rx_valid is asserted SYNC_STAGES+1 clks after the 8th raw SCK rising edge.
  - MISO update is SYNC_STAGES+1 clks after the raw SCK falling edge; this latency sets the clk >= 8x SCK requirement.
- rx_valid has no backpressure; each byte overwrites rx_data.
- Reset mid-transfer: all state returns to reset values immediately. The transfer resumes only after a fresh csn fall.

Test Plan:
- Reset, then hold csn=1 -> spi_miso_oe=0, tx_ready=1, busy=0, rx_valid never pulses.
- Offer tx_data=8'hA5; master sends 8'h3C in one 8-clock frame -> MISO bits read 1,0,1,0,0,1,0,1; rx_data=8'h3C with one rx_valid pulse; tx_ready back to 1.
- No tx byte offered; master clocks 2 bytes 8'h01, 8'h80 -> MISO returns 8'hFF,8'hFF; rx_valid pulses twice, rx_data 8'h01 then 8'h80.
- Offer 8'h11, then 8'h22 during byte 0 -> MISO returns 8'h11 then 8'h22; the second handshake completes only after the first byte loads.
- csn deasserted after 5 SCK edges of 8'hFF -> no rx_valid; spi_miso_oe=0 next cycle; the next full frame 8'h5A gives rx_data=8'h5A.
- Assert rst after bit 3 of a frame, release, new frame 8'hC3 -> outputs at reset values during rst; rx_data=8'hC3 after the frame; MISO = IDLE_BYTE.
